// File: rtl/ddio_bidir_burst_sequencer_if.sv
// ---------------------------------------------------------------------------
// ddio_bidir_burst_sequencer_if
// Groups the user-side write/read streams and the DDIO pad-side signals of
// the burst sequencer into one bundle.
//   master : user / environment side (drives requests, write data, pad
//            captures; observes ready/valid/busy and pad drive)
//   slave  : sequencer side
// Signals:
//   wr_req, wr_ready, wr_data_h, wr_data_l      write stream
//   rd_req, rd_valid, rd_data_h, rd_data_l      read stream
//   busy                                        sequencer not idle
//   ddio_datain_h, ddio_datain_l, ddio_oe       to DDIO pad atom
//   ddio_dataout_h, ddio_dataout_l              from DDIO pad atom
// ---------------------------------------------------------------------------
interface ddio_bidir_burst_sequencer_if #(
  parameter int unsigned WIDTH = 8
);

  logic             wr_req;
  logic             wr_ready;
  logic [WIDTH-1:0] wr_data_h;
  logic [WIDTH-1:0] wr_data_l;

  logic             rd_req;
  logic             rd_valid;
  logic [WIDTH-1:0] rd_data_h;
  logic [WIDTH-1:0] rd_data_l;

  logic             busy;

  logic [WIDTH-1:0] ddio_datain_h;
  logic [WIDTH-1:0] ddio_datain_l;
  logic             ddio_oe;
  logic [WIDTH-1:0] ddio_dataout_h;
  logic [WIDTH-1:0] ddio_dataout_l;

  modport master (
    output wr_req, wr_data_h, wr_data_l, rd_req, ddio_dataout_h, ddio_dataout_l,
    input  wr_ready, rd_valid, rd_data_h, rd_data_l, busy,
           ddio_datain_h, ddio_datain_l, ddio_oe
  );

  modport slave (
    input  wr_req, wr_data_h, wr_data_l, rd_req, ddio_dataout_h, ddio_dataout_l,
    output wr_ready, rd_valid, rd_data_h, rd_data_l, busy,
           ddio_datain_h, ddio_datain_l, ddio_oe
  );

endinterface

// File: rtl/ddio_bidir_burst_sequencer.sv
// ---------------------------------------------------------------------------
// ddio_bidir_burst_sequencer
// Single-clock burst sequencer feeding a bidirectional DDIO pad wrapper.
// Write bursts: one-cycle OE preamble, BURST_LEN data beats, one-cycle OE
// postamble. Read bursts: RD_LATENCY wait cycles, BURST_LEN capture cycles,
// then one turnaround cycle before returning to idle.
// Ports:
//   clock : sole clock (also the DDIO inclk/outclk)
//   sclr  : synchronous active-high reset
//   bus   : slave side of ddio_bidir_burst_sequencer_if
//           wr_ready and busy are combinational; all other outputs are
//           registered.
// ---------------------------------------------------------------------------
module ddio_bidir_burst_sequencer #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned BURST_LEN  = 4,
  parameter int unsigned RD_LATENCY = 3
) (
  input logic                         clock,
  input logic                         sclr,
  ddio_bidir_burst_sequencer_if.slave bus
);

  localparam int unsigned CNT_MAX = (BURST_LEN > RD_LATENCY) ? BURST_LEN : RD_LATENCY;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0] LAT_LAST   = CNT_W'(RD_LATENCY - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_PRE  = 3'd1,
    ST_WR_DATA = 3'd2,
    ST_WR_POST = 3'd3,
    ST_RD_WAIT = 3'd4,
    ST_RD_DATA = 3'd5,
    ST_TURN    = 3'd6
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             oe_q, oe_d;
  logic [WIDTH-1:0] din_h_q, din_h_d;
  logic [WIDTH-1:0] din_l_q, din_l_d;
  logic             rd_valid_q, rd_valid_d;
  logic [WIDTH-1:0] rd_h_q, rd_h_d;
  logic [WIDTH-1:0] rd_l_q, rd_l_d;

  logic             wr_ready_c;
  logic             rd_cap_c;

  // Next-state, beat counter and registered-output next values
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wr_ready_c = 1'b0;
    rd_cap_c   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        // Write has priority; requests elsewhere are simply not looked at.
        if (bus.wr_req) begin
          state_d = ST_WR_PRE;
        end else if (bus.rd_req) begin
          state_d = ST_RD_WAIT;
        end
      end

      ST_WR_PRE: begin
        // First beat is taken during the preamble so it lands on the pad in
        // WR_DATA cycle 0.
        wr_ready_c = 1'b1;
        cnt_d      = '0;
        state_d    = ST_WR_DATA;
      end

      ST_WR_DATA: begin
        wr_ready_c = (cnt_q != BURST_LAST);
        if (cnt_q == BURST_LAST) begin
          cnt_d   = '0;
          state_d = ST_WR_POST;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_WR_POST: begin
        state_d = ST_IDLE;
      end

      ST_RD_WAIT: begin
        if (cnt_q == LAT_LAST) begin
          cnt_d   = '0;
          state_d = ST_RD_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_RD_DATA: begin
        rd_cap_c = 1'b1;
        if (cnt_q == BURST_LAST) begin
          cnt_d   = '0;
          state_d = ST_TURN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_TURN: begin
        state_d = ST_IDLE;
      end

      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase

    // OE follows the upcoming state so the pad sees it in the same cycle
    // the write state is entered, straight from a flop.
    oe_d = (state_d == ST_WR_PRE) || (state_d == ST_WR_DATA) || (state_d == ST_WR_POST);

    // A beat accepted now is driven next cycle; otherwise the pad data is 0.
    din_h_d = wr_ready_c ? bus.wr_data_h : '0;
    din_l_d = wr_ready_c ? bus.wr_data_l : '0;

    // Read capture holds its last value between beats.
    rd_valid_d = rd_cap_c;
    rd_h_d     = rd_cap_c ? bus.ddio_dataout_h : rd_h_q;
    rd_l_d     = rd_cap_c ? bus.ddio_dataout_l : rd_l_q;
  end

  // State, counter and output registers with synchronous clear
  always_ff @(posedge clock) begin
    if (sclr) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      oe_q       <= 1'b0;
      din_h_q    <= '0;
      din_l_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_h_q     <= '0;
      rd_l_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      oe_q       <= oe_d;
      din_h_q    <= din_h_d;
      din_l_q    <= din_l_d;
      rd_valid_q <= rd_valid_d;
      rd_h_q     <= rd_h_d;
      rd_l_q     <= rd_l_d;
    end
  end

  assign bus.wr_ready      = wr_ready_c;
  assign bus.busy          = (state_q != ST_IDLE);
  assign bus.ddio_oe       = oe_q;
  assign bus.ddio_datain_h = din_h_q;
  assign bus.ddio_datain_l = din_l_q;
  assign bus.rd_valid      = rd_valid_q;
  assign bus.rd_data_h     = rd_h_q;
  assign bus.rd_data_l     = rd_l_q;

endmodule

// File: doc/ddio_bidir_burst_sequencer.md
Name: ddio_bidir_burst_sequencer

Overview:
- Single-clock sequencer that sits directly upstream of the bidirectional DDIO pad atom wrapper (no-areset variant).
- On the write side it drives datain_h/datain_l/oe, with one-cycle OE preamble and postamble around a fixed-length burst.
- On the read side it consumes dataout_h/dataout_l after a fixed round-trip latency and presents them as a valid-qualified stream.
- Write and read bursts are mutually exclusive. A bus-turnaround cycle follows every read.

Parameters:
- WIDTH, 8: width of each DDR half-word (h and l).
- BURST_LEN, 4: beats per burst (one beat = one h/l pair per clock). Legal range 2..64.
- RD_LATENCY, 3: cycles between read start and first valid pad capture. Legal range 1..15.

Ports:
- clock  in  1  Sole clock. Also drives the DDIO inclk/outclk.
- sclr  in  1  Synchronous reset, active-high.
- wr_req  in  1  Write-burst request. Sampled only in IDLE.
- wr_ready  out  1  High when a wr_data beat is consumed in this cycle.
- wr_data_h  in  WIDTH  Write beat, rising-edge half.
- wr_data_l  in  WIDTH  Write beat, falling-edge half.
- rd_req  in  1  Read-burst request. Sampled only in IDLE.
- rd_valid  out  1  rd_data holds a captured beat.
- rd_data_h  out  WIDTH  Captured beat from ddio_dataout_h.
- rd_data_l  out  WIDTH  Captured beat from ddio_dataout_l.
- busy  out  1  State is not IDLE.
- ddio_datain_h  out  WIDTH  To DDIO datain_h.
- ddio_datain_l  out  WIDTH  To DDIO datain_l.
- ddio_oe  out  1  To DDIO oe.
- ddio_dataout_h  in  WIDTH  From DDIO dataout_h.
- ddio_dataout_l  in  WIDTH  From DDIO dataout_l.

Behaviour:
- Clocking and reset:
  - One clock (clock). Reset sclr is synchronous and active-high.
  - While sclr is high at an edge, the block enters IDLE and clears all counters. All registered outputs go to 0: ddio_oe, ddio_datain_h/l, rd_valid, rd_data_h/l.
  - A reset mid-burst abandons the burst. The next cycle has ddio_oe=0 and no further rd_valid or wr_ready.
- States: IDLE, WR_PRE, WR_DATA, WR_POST, RD_WAIT, RD_DATA, TURN. A beat counter tracks position within WR_DATA, RD_WAIT and RD_DATA.
- IDLE:
  - wr_req=1 goes to WR_PRE. Otherwise rd_req=1 goes to RD_WAIT. Write wins when both are high.
  - Requests outside IDLE are ignored and never queued.
- WR_PRE (1 cycle):
  - ddio_oe=1, ddio_datain=0.
  - Leaves for WR_DATA.
- WR_DATA (BURST_LEN cycles), then WR_POST:
  - ddio_oe=1. ddio_datain carries beat k during WR_DATA cycle k.
- WR_POST (1 cycle), then IDLE:
  - ddio_oe=1, ddio_datain=0.
- wr_ready rules:
  - wr_ready is combinational from state and counter. It is 1 in WR_PRE and in WR_DATA cycles 0..BURST_LEN-2, giving exactly BURST_LEN cycles.
  - wr_data is sampled whenever wr_ready=1. The user side has no backpressure.
  - Beat sampled at wr_ready cycle k appears on ddio_datain_h/l one cycle later.
- Write-burst OE window: ddio_oe is high for exactly BURST_LEN+2 consecutive cycles.
- RD_WAIT (RD_LATENCY cycles), then RD_DATA:
  - ddio_oe=0.
- RD_DATA (BURST_LEN cycles), then TURN:
  - ddio_oe=0.
  - Each cycle, ddio_dataout_h/l is registered into rd_data_h/l with rd_valid=1 on the following cycle.
- TURN (1 cycle), then IDLE:
  - ddio_oe=0. Guarantees at least one dead cycle before any write preamble.
- Read timing: with rd_req sampled in IDLE at cycle 0, rd_valid is high in cycles RD_LATENCY+2 .. RD_LATENCY+BURST_LEN+1.
  - rd_valid is never high outside that window.
  - rd_data holds its last value when rd_valid=0.
- ddio_oe is registered, so it has no combinational glitch.
- Outside WR_DATA, ddio_datain is forced to 0.
- busy = (state != IDLE), combinational.
- Back-to-back write bursts: WR_POST goes to IDLE, which can re-enter WR_PRE the next cycle. Minimum write-to-write period is BURST_LEN+3 cycles.
- Read-to-write: minimum gap is the TURN cycle plus IDLE, so at least 2 cycles with ddio_oe=0 between the last RD_DATA cycle and WR_PRE.

Test Plan (WIDTH=8, BURST_LEN=4, RD_LATENCY=3):
- Write burst: wr_req pulse at cycle 0; wr_data_h/l = 11/21, 12/22, 13/23, 14/24 on the four wr_ready cycles (1–4). Required: ddio_oe=1 in cycles 1–6; ddio_datain = 11/21..14/24 in cycles 2–5; 0 in cycles 1 and 6; busy falls at cycle 7.
- Read burst: rd_req at cycle 0; ddio_dataout = A0/B0..A3/B3 in cycles 4–7. Required: rd_valid=1 in cycles 5–8 with matching data; ddio_oe=0 throughout; TURN at cycle 8, IDLE at cycle 9.
- Simultaneous wr_req and rd_req in IDLE: write executes and rd_req is dropped. wr_req/rd_req pulses during busy produce no extra burst.
- Read immediately followed by write (wr_req held high): at least 2 cycles of ddio_oe=0 between the last RD_DATA cycle and ddio_oe rising.
- sclr asserted during WR_DATA cycle 2: next cycle ddio_oe=0, datain=0, wr_ready=0, busy=0. A subsequent wr_req runs a full clean burst.
- sclr during RD_WAIT: no rd_valid ever asserts for that burst.
